m_ctrl_fsm: RTL and testbench
=============================

M_CTRL_FSM -- requirements
Module: m_ctrl_fsm

Interface
REQ-001 Parameter WAIT_LIMIT, default 8, max consecutive MIO_ready-low cycles tolerated in a memory state; 0 = wait forever.
REQ-002 Parameter HAS_JAL, default 1, enables jal decode; when 0, jal is illegal.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 MIO_ready  in  1  memory handshake, transfer completes in a cycle where high.
REQ-006 Inst  in  32  current IR contents; opcode [31:26], funct [5:0].
REQ-007 zero  in  1  ALU zero flag, informational only; the datapath performs branch qualification.
REQ-008 ctrl  out  14  {PCWrite, PCWriteCond, IorD, IRWrite, MemtoReg[1:0], PCSource[1:0], ALUSrcB[1:0], ALUSrcA, RegWrite, RegDst[1:0]}.
REQ-009 Branch  out  1  1 = beq sense, 0 = bne sense.
REQ-010 ALU_operation  out  3  AND 000, OR 001, ADD 010, XOR 011, NOR 100, SRL 101, SUB 110, SLT 111.
REQ-011 MemRead, MemWrite  out  1 each  memory strobes; CPU_MIO  out  1  memory access in progress.
REQ-012 illegal_inst  out  1  one-cycle pulse on undecodable instruction.
REQ-013 bus_fault  out  1  sticky, WAIT_LIMIT exceeded.
REQ-014 state_out  out  5  current state encoding for debug.

Function
REQ-015 States SHALL be IF, ID, EX_R, WB_R, EX_I, WB_I, LUI_WB, EX_MEM, MEM_RD, MEM_WR, WB_LW, EX_BEQ, EX_BNE, EX_J, EX_JR, EX_JAL, ILLEGAL, FAULT; all outputs are Moore-decoded from state except MIO_ready gating (REQ-016).
REQ-016 IF: ctrl 1_00_1_00_00_01_0_0_00, ALU ADD, MemRead=1, CPU_MIO=1; PCWrite and IRWrite SHALL be asserted only in a cycle with MIO_ready=1; state stays IF while MIO_ready=0.
REQ-017 ID: ctrl all zero except ALUSrcB=11, ALU ADD; always one cycle; decodes to next state.
REQ-018 R-type (opcode 000000): funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 000010 SRL -> EX_R (ALUSrcA=1, ALUSrcB=00) -> WB_R (EX_R plus RegWrite=1, RegDst=01) -> IF; funct 001000 -> EX_JR (PCWrite=1, ALUSrcA=1, ALUSrcB=00, ADD, PCSource=00) -> IF.
REQ-019 I-type: addi 001000 ADD, slti 001010 SLT, andi 001100 AND, ori 001101 OR, xori 001110 XOR -> EX_I (ALUSrcA=1, ALUSrcB=10) -> WB_I (EX_I plus RegWrite=1, RegDst=00) -> IF; lui 001111 -> LUI_WB (MemtoReg=01, ALUSrcB=11, RegWrite=1) -> IF.
REQ-020 lw 100011 / sw 101011 -> EX_MEM (ALUSrcA=1, ALUSrcB=10, ADD) -> MEM_RD (IorD=1, MemRead=1) or MEM_WR (IorD=1, MemWrite=1); each held while MIO_ready=0; MEM_RD -> WB_LW (MemtoReg=10, RegWrite=1, RegDst=00) -> IF; MEM_WR -> IF.
REQ-021 beq 000100 -> EX_BEQ, bne 000101 -> EX_BNE: PCWriteCond=1, PCSource=01, ALUSrcA=1, ALUSrcB=00, SUB, Branch=1/0 -> IF.
REQ-022 j 000010 -> EX_J: PCWrite=1, PCSource=10 -> IF; jal 000011 (HAS_JAL=1) -> EX_JAL: EX_J plus RegWrite=1, RegDst=10, MemtoReg=11 -> IF.
REQ-023 Any other opcode/funct -> ILLEGAL: ctrl all zero, illegal_inst=1 for exactly one cycle -> IF.
REQ-024 Wait counter SHALL clear on every entry to IF/MEM_RD/MEM_WR and on MIO_ready=1, increment each MIO_ready-low cycle in those states; on reaching WAIT_LIMIT (nonzero) -> FAULT.
REQ-025 FAULT: ctrl, strobes zero, bus_fault=1, held until reset.
REQ-026 Counter width SHALL be clog2(WAIT_LIMIT+1), minimum 1 bit, no wrap when WAIT_LIMIT=0 (counter frozen).

Reset
REQ-027 reset low SHALL immediately force state IF, wait counter 0, bus_fault 0, illegal_inst 0, including mid-access or in FAULT.
REQ-028 During reset, outputs SHALL decode IF but PCWrite/IRWrite SHALL be 0.

Structure
REQ-029 State encodings, ALU_operation codes, opcode/funct constants and ctrl field positions SHALL reside in shared package m_ctrl_pkg.
REQ-030 One sub-module m_ctrl_decode (combinational opcode/funct to next-state and ALU op) SHALL be used; FSM and counter live in m_ctrl_fsm.

Verification
REQ-031 Inst=0x00000827 (nor r1,r0,r0), MIO_ready=1 -> states IF,ID,EX_R,WB_R; ALU NOR in EX_R; RegWrite=1 only in WB_R.
REQ-032 lw 0x8C010004 with MIO_ready low 3 cycles in MEM_RD, WAIT_LIMIT=8 -> MEM_RD held 4 cycles, then WB_LW, no fault.
REQ-033 MIO_ready stuck low in IF, WAIT_LIMIT=8 -> FAULT after 8 cycles, bus_fault=1 sticky; reset low -> IF, bus_fault=0.
REQ-034 Inst=0xFC000000 -> IF,ID,ILLEGAL,IF; illegal_inst high exactly 1 cycle; HAS_JAL=0 with 0x0C000400 -> same.
REQ-035 beq 0x10000004 then bne 0x14000004 -> EX_BEQ Branch=1, EX_BNE Branch=0, both PCWriteCond=1, SUB.
REQ-036 reset asserted in MEM_WR with MemWrite=1 -> MemWrite drops asynchronously, state_out=IF.

Source files
------------

// File: rtl/m_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, ALU op codes,
// opcode/funct constants and the ctrl bus field layout.
package m_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF      = 5'd0,
        S_ID      = 5'd1,
        S_EX_R    = 5'd2,
        S_WB_R    = 5'd3,
        S_EX_I    = 5'd4,
        S_WB_I    = 5'd5,
        S_LUI_WB  = 5'd6,
        S_EX_MEM  = 5'd7,
        S_MEM_RD  = 5'd8,
        S_MEM_WR  = 5'd9,
        S_WB_LW   = 5'd10,
        S_EX_BEQ  = 5'd11,
        S_EX_BNE  = 5'd12,
        S_EX_J    = 5'd13,
        S_EX_JR   = 5'd14,
        S_EX_JAL  = 5'd15,
        S_ILLEGAL = 5'd16,
        S_FAULT   = 5'd17
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    // Field order fixes the bit positions of the 14-bit ctrl output, MSB first.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic [1:0] reg_dst;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    function automatic int wait_cnt_w(input int lim);
        return (lim <= 0) ? 1 : $clog2(lim + 1);
    endfunction

endpackage

// File: rtl/m_ctrl_decode.sv
// Combinational instruction decode: opcode/funct to post-ID state and ALU op.
// Zero latency; no handshake.
module m_ctrl_decode
    import m_ctrl_pkg::*;
#(
    parameter bit HAS_JAL = 1'b1
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output state_t     nxt,
    output alu_op_t    alu
);

    always_comb begin
        nxt = S_ILLEGAL;
        alu = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin nxt = S_EX_R; alu = ALU_ADD; end
                    FN_SUB: begin nxt = S_EX_R; alu = ALU_SUB; end
                    FN_AND: begin nxt = S_EX_R; alu = ALU_AND; end
                    FN_OR:  begin nxt = S_EX_R; alu = ALU_OR;  end
                    FN_XOR: begin nxt = S_EX_R; alu = ALU_XOR; end
                    FN_NOR: begin nxt = S_EX_R; alu = ALU_NOR; end
                    FN_SLT: begin nxt = S_EX_R; alu = ALU_SLT; end
                    FN_SRL: begin nxt = S_EX_R; alu = ALU_SRL; end
                    FN_JR:  nxt = S_EX_JR;
                    default: nxt = S_ILLEGAL;
                endcase
            end
            OP_ADDI: begin nxt = S_EX_I; alu = ALU_ADD; end
            OP_SLTI: begin nxt = S_EX_I; alu = ALU_SLT; end
            OP_ANDI: begin nxt = S_EX_I; alu = ALU_AND; end
            OP_ORI:  begin nxt = S_EX_I; alu = ALU_OR;  end
            OP_XORI: begin nxt = S_EX_I; alu = ALU_XOR; end
            OP_LUI:  nxt = S_LUI_WB;
            OP_LW,
            OP_SW:   nxt = S_EX_MEM;
            OP_BEQ:  begin nxt = S_EX_BEQ; alu = ALU_SUB; end
            OP_BNE:  begin nxt = S_EX_BNE; alu = ALU_SUB; end
            OP_J:    nxt = S_EX_J;
            OP_JAL:  nxt = HAS_JAL ? S_EX_JAL : S_ILLEGAL;
            default: nxt = S_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/m_ctrl_fsm.sv
// Multicycle CPU control FSM with memory-wait watchdog; outputs Moore-decoded from state.
// IF/MEM_RD/MEM_WR stall while MIO_ready is low; WAIT_LIMIT low cycles in a row lands in FAULT.
module m_ctrl_fsm
    import m_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 8,
    parameter bit HAS_JAL    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MIO_ready,
    input  logic [31:0]       Inst,
    input  logic              zero,
    output logic [CTRL_W-1:0] ctrl,
    output logic              Branch,
    output logic [2:0]        ALU_operation,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              CPU_MIO,
    output logic              illegal_inst,
    output logic              bus_fault,
    output logic [4:0]        state_out
);

    localparam int CW = wait_cnt_w(WAIT_LIMIT);
    localparam logic [CW-1:0] LIM_M1 = CW'((WAIT_LIMIT <= 0) ? 0 : WAIT_LIMIT - 1);

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    alu_op_t         alu_q;
    state_t          dec_nxt;
    alu_op_t         dec_alu;
    logic            waiting;
    logic            timeout;
    ctrl_t           c;
    alu_op_t         alu;
    logic            unused_bits;

    // The branch decision is made in the datapath; zero and the immediate bits are not needed here.
    assign unused_bits = ^{zero, Inst[25:6]};

    m_ctrl_decode #(.HAS_JAL(HAS_JAL)) u_decode (
        .opcode (Inst[31:26]),
        .funct  (Inst[5:0]),
        .nxt    (dec_nxt),
        .alu    (dec_alu)
    );

    assign waiting = (state == S_IF || state == S_MEM_RD || state == S_MEM_WR) && !MIO_ready;
    assign timeout = waiting && (WAIT_LIMIT > 0) && (wait_cnt == LIM_M1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IF;
            wait_cnt <= '0;
            alu_q    <= ALU_ADD;
        end else begin
            // Any state change or completed handshake clears the count, so entry always starts at zero.
            if (waiting && (WAIT_LIMIT > 0) && !timeout)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            case (state)
                S_IF: begin
                    if (MIO_ready)    state <= S_ID;
                    else if (timeout) state <= S_FAULT;
                end
                S_ID: begin
                    state <= dec_nxt;
                    alu_q <= dec_alu;
                end
                S_EX_R:   state <= S_WB_R;
                S_EX_I:   state <= S_WB_I;
                S_EX_MEM: state <= (Inst[31:26] == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (MIO_ready)    state <= S_WB_LW;
                    else if (timeout) state <= S_FAULT;
                end
                S_MEM_WR: begin
                    if (MIO_ready)    state <= S_IF;
                    else if (timeout) state <= S_FAULT;
                end
                S_FAULT:  state <= S_FAULT;
                default:  state <= S_IF;
            endcase
        end
    end

    always_comb begin
        c        = '0;
        alu      = ALU_ADD;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        CPU_MIO  = 1'b0;
        case (state)
            S_IF: begin
                // Reset is folded in so a held reset never commits a fetch.
                c.pc_write = MIO_ready & reset;
                c.ir_write = MIO_ready & reset;
                c.alu_src_b = 2'b01;
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
            end
            S_ID: c.alu_src_b = 2'b11;
            S_EX_R: begin
                c.alu_src_a = 1'b1;
                alu = alu_q;
            end
            S_WB_R: begin
                c.alu_src_a = 1'b1;
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b01;
                alu = alu_q;
            end
            S_EX_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                alu = alu_q;
            end
            S_WB_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.reg_write = 1'b1;
                alu = alu_q;
            end
            S_LUI_WB: begin
                c.mem_to_reg = 2'b01;
                c.alu_src_b  = 2'b11;
                c.reg_write  = 1'b1;
            end
            S_EX_MEM: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                c.ior_d = 1'b1;
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
            end
            S_MEM_WR: begin
                c.ior_d  = 1'b1;
                MemWrite = 1'b1;
                CPU_MIO  = 1'b1;
            end
            S_WB_LW: begin
                c.mem_to_reg = 2'b10;
                c.reg_write  = 1'b1;
            end
            S_EX_BEQ, S_EX_BNE: begin
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.alu_src_a     = 1'b1;
                alu    = ALU_SUB;
                Branch = (state == S_EX_BEQ);
            end
            S_EX_J: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_EX_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b10;
                c.mem_to_reg = 2'b11;
            end
            S_EX_JR: begin
                c.pc_write  = 1'b1;
                c.alu_src_a = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl          = c;
    assign ALU_operation = alu;
    assign illegal_inst  = (state == S_ILLEGAL);
    assign bus_fault     = (state == S_FAULT);
    assign state_out     = state;

endmodule

// File: tb/tb_m_ctrl_fsm.sv
// Scoreboard bench: the driver queues hand-computed per-cycle expectations, a negedge monitor checks them.
module tb_m_ctrl_fsm;
    import m_ctrl_pkg::*;

    typedef struct {
        string       name;
        logic [4:0]  st;
        logic [13:0] ctrl;
        int          alu;
        logic [4:0]  fl;
        int          br;
    } exp_t;

    localparam int DC = -1;
    localparam int A_AND = 0, A_OR = 1, A_ADD = 2, A_NOR = 4, A_SRL = 5, A_SUB = 6;
    // flags = {MemRead, MemWrite, CPU_MIO, illegal_inst, bus_fault}
    localparam logic [4:0] F_0 = 5'b00000, F_IF = 5'b10100, F_WR = 5'b01100;
    localparam logic [4:0] F_ILL = 5'b00010, F_FLT = 5'b00001;

    localparam logic [13:0] C_IF    = 14'b1_0_0_1_00_00_01_0_0_00;
    localparam logic [13:0] C_IFW   = 14'b0_0_0_0_00_00_01_0_0_00;
    localparam logic [13:0] C_ID    = 14'b0_0_0_0_00_00_11_0_0_00;
    localparam logic [13:0] C_EXR   = 14'b0_0_0_0_00_00_00_1_0_00;
    localparam logic [13:0] C_WBR   = 14'b0_0_0_0_00_00_00_1_1_01;
    localparam logic [13:0] C_EXI   = 14'b0_0_0_0_00_00_10_1_0_00;
    localparam logic [13:0] C_WBI   = 14'b0_0_0_0_00_00_10_1_1_00;
    localparam logic [13:0] C_LUI   = 14'b0_0_0_0_01_00_11_0_1_00;
    localparam logic [13:0] C_MEM   = 14'b0_0_1_0_00_00_00_0_0_00;
    localparam logic [13:0] C_WBLW  = 14'b0_0_0_0_10_00_00_0_1_00;
    localparam logic [13:0] C_BR    = 14'b0_1_0_0_00_01_00_1_0_00;
    localparam logic [13:0] C_J     = 14'b1_0_0_0_00_10_00_0_0_00;
    localparam logic [13:0] C_JAL   = 14'b1_0_0_0_11_10_00_0_1_10;
    localparam logic [13:0] C_JR    = 14'b1_0_0_0_00_00_00_1_0_00;
    localparam logic [13:0] C_0     = 14'b0;

    logic        clk;
    logic        reset;
    logic        mio;
    logic [31:0] inst;
    logic        zero;

    logic [13:0] ctrl0, ctrl1;
    logic        br0, br1, rd0, rd1, wr0, wr1, cm0, cm1, ill0, ill1, flt0, flt1;
    logic [2:0]  alu0, alu1;
    logic [4:0]  st0, st1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    m_ctrl_fsm #(.WAIT_LIMIT(8), .HAS_JAL(1'b1)) dut (
        .clk(clk), .reset(reset), .MIO_ready(mio), .Inst(inst), .zero(zero),
        .ctrl(ctrl0), .Branch(br0), .ALU_operation(alu0), .MemRead(rd0), .MemWrite(wr0),
        .CPU_MIO(cm0), .illegal_inst(ill0), .bus_fault(flt0), .state_out(st0)
    );

    m_ctrl_fsm #(.WAIT_LIMIT(8), .HAS_JAL(1'b0)) dut_nojal (
        .clk(clk), .reset(reset), .MIO_ready(mio), .Inst(inst), .zero(zero),
        .ctrl(ctrl1), .Branch(br1), .ALU_operation(alu1), .MemRead(rd1), .MemWrite(wr1),
        .CPU_MIO(cm1), .illegal_inst(ill1), .bus_fault(flt1), .state_out(st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string nm, input logic [4:0] st, input logic [13:0] c,
                                input int alu, input logic [4:0] fl, input int br);
        exp_t e;
        e.name = nm; e.st = st; e.ctrl = c; e.alu = alu; e.fl = fl; e.br = br;
        return e;
    endfunction

    task automatic chk(input exp_t e, input logic [4:0] st, input logic [13:0] c,
                       input logic [2:0] alu, input logic [4:0] fl, input logic br);
        logic ok;
        ok = (st == e.st) && (c == e.ctrl) && (fl == e.fl)
             && (e.alu < 0 || alu == 3'(e.alu)) && (e.br < 0 || br == 1'(e.br));
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got state=%0d ctrl=%b alu=%0d flags=%b br=%b, want state=%0d ctrl=%b alu=%0d flags=%b br=%0d",
                     e.name, st, c, alu, fl, br, e.st, e.ctrl, e.alu, e.fl, e.br);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) chk(q0.pop_front(), st0, ctrl0, alu0, {rd0, wr0, cm0, ill0, flt0}, br0);
        if (q1.size() > 0) chk(q1.pop_front(), st1, ctrl1, alu1, {rd1, wr1, cm1, ill1, flt1}, br1);
    end

    // Applies one cycle of inputs and queues what the main DUT must show during that cycle.
    task automatic cyc(input logic r, input logic m, input logic [31:0] i, input string nm,
                       input logic [4:0] st, input logic [13:0] c, input int alu,
                       input logic [4:0] fl, input int br);
        reset = r; mio = m; inst = i;
        q0.push_back(mk(nm, st, c, alu, fl, br));
        @(posedge clk);
        #1;
    endtask

    task automatic nj(input string nm, input logic [4:0] st, input logic [13:0] c,
                      input int alu, input logic [4:0] fl);
        q1.push_back(mk(nm, st, c, alu, fl, DC));
    endtask

    localparam logic [31:0] I_NOR = 32'h0000_0827, I_SRL = 32'h0000_0002, I_JR = 32'h0000_0008;
    localparam logic [31:0] I_ADDI = 32'h2000_0000, I_ORI = 32'h3400_0000, I_LUI = 32'h3C00_0000;
    localparam logic [31:0] I_LW = 32'h8C01_0004, I_SW = 32'hAC01_0004;
    localparam logic [31:0] I_BEQ = 32'h1000_0004, I_BNE = 32'h1400_0004;
    localparam logic [31:0] I_J = 32'h0800_0400, I_JAL = 32'h0C00_0400;
    localparam logic [31:0] I_BAD = 32'hFC00_0000, I_BADF = 32'h0000_003F;

    initial begin
        reset = 1'b0; mio = 1'b1; inst = '0; zero = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 1, 0, "rst_if_gated", S_IF, C_IFW, A_ADD, F_IF, DC);
        cyc(0, 0, 0, "rst_if_low", S_IF, C_IFW, A_ADD, F_IF, DC);

        cyc(1, 0, I_NOR, "if_stall", S_IF, C_IFW, A_ADD, F_IF, DC);
        cyc(1, 1, I_NOR, "nor_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_NOR, "nor_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_NOR, "nor_ex", S_EX_R, C_EXR, A_NOR, F_0, DC);
        cyc(1, 1, I_NOR, "nor_wb", S_WB_R, C_WBR, A_NOR, F_0, DC);

        cyc(1, 1, I_SRL, "srl_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_SRL, "srl_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_SRL, "srl_ex", S_EX_R, C_EXR, A_SRL, F_0, DC);
        cyc(1, 1, I_SRL, "srl_wb", S_WB_R, C_WBR, A_SRL, F_0, DC);

        cyc(1, 1, I_JR, "jr_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_JR, "jr_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_JR, "jr_ex", S_EX_JR, C_JR, A_ADD, F_0, DC);

        cyc(1, 1, I_ADDI, "addi_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_ADDI, "addi_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_ADDI, "addi_ex", S_EX_I, C_EXI, A_ADD, F_0, DC);
        cyc(1, 1, I_ADDI, "addi_wb", S_WB_I, C_WBI, A_ADD, F_0, DC);

        cyc(1, 1, I_ORI, "ori_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_ORI, "ori_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_ORI, "ori_ex", S_EX_I, C_EXI, A_OR, F_0, DC);
        cyc(1, 1, I_ORI, "ori_wb", S_WB_I, C_WBI, A_OR, F_0, DC);

        // Seven stalled fetch cycles is one short of the limit.
        for (int k = 0; k < 7; k++) cyc(1, 0, I_LUI, "if_stall7", S_IF, C_IFW, A_ADD, F_IF, DC);
        cyc(1, 1, I_LUI, "lui_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_LUI, "lui_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_LUI, "lui_wb", S_LUI_WB, C_LUI, DC, F_0, DC);

        cyc(1, 1, I_LW, "lw_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_LW, "lw_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_LW, "lw_ex", S_EX_MEM, C_EXI, A_ADD, F_0, DC);
        for (int k = 0; k < 3; k++) cyc(1, 0, I_LW, "lw_mem_wait", S_MEM_RD, C_MEM, DC, F_IF, DC);
        cyc(1, 1, I_LW, "lw_mem_done", S_MEM_RD, C_MEM, DC, F_IF, DC);
        cyc(1, 1, I_LW, "lw_wb", S_WB_LW, C_WBLW, DC, F_0, DC);

        cyc(1, 1, I_SW, "sw_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_SW, "sw_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_SW, "sw_ex", S_EX_MEM, C_EXI, A_ADD, F_0, DC);
        cyc(1, 1, I_SW, "sw_mem", S_MEM_WR, C_MEM, DC, F_WR, DC);

        cyc(1, 1, I_BEQ, "beq_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_BEQ, "beq_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_BEQ, "beq_ex", S_EX_BEQ, C_BR, A_SUB, F_0, 1);
        cyc(1, 1, I_BNE, "bne_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_BNE, "bne_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_BNE, "bne_ex", S_EX_BNE, C_BR, A_SUB, F_0, 0);

        cyc(1, 1, I_J, "j_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_J, "j_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_J, "j_ex", S_EX_J, C_J, DC, F_0, DC);

        // jal runs on both instances: legal with HAS_JAL=1, illegal without.
        nj("nojal_if", S_IF, C_IF, A_ADD, F_IF);
        cyc(1, 1, I_JAL, "jal_if", S_IF, C_IF, A_ADD, F_IF, DC);
        nj("nojal_id", S_ID, C_ID, A_ADD, F_0);
        cyc(1, 1, I_JAL, "jal_id", S_ID, C_ID, A_ADD, F_0, DC);
        nj("nojal_ill", S_ILLEGAL, C_0, DC, F_ILL);
        cyc(1, 1, I_JAL, "jal_ex", S_EX_JAL, C_JAL, DC, F_0, DC);
        nj("nojal_back_if", S_IF, C_IF, A_ADD, F_IF);

        cyc(1, 1, I_BAD, "bad_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_BAD, "bad_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_BAD, "bad_ill", S_ILLEGAL, C_0, DC, F_ILL, DC);
        cyc(1, 1, I_BADF, "badf_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_BADF, "badf_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_BADF, "badf_ill", S_ILLEGAL, C_0, DC, F_ILL, DC);

        // Reset dropped mid-cycle during a stalled store: outputs must fall back to IF before any edge.
        cyc(1, 1, I_SW, "sw2_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_SW, "sw2_id", S_ID, C_ID, A_ADD, F_0, DC);
        cyc(1, 1, I_SW, "sw2_ex", S_EX_MEM, C_EXI, A_ADD, F_0, DC);
        cyc(1, 0, I_SW, "sw2_mem", S_MEM_WR, C_MEM, DC, F_WR, DC);
        cyc(0, 1, I_SW, "rst_in_memwr", S_IF, C_IFW, A_ADD, F_IF, DC);

        for (int k = 0; k < 8; k++) cyc(1, 0, I_NOR, "if_stall8", S_IF, C_IFW, A_ADD, F_IF, DC);
        cyc(1, 1, I_NOR, "fault", S_FAULT, C_0, DC, F_FLT, DC);
        cyc(1, 0, I_NOR, "fault_sticky", S_FAULT, C_0, DC, F_FLT, DC);
        cyc(1, 1, I_NOR, "fault_sticky2", S_FAULT, C_0, DC, F_FLT, DC);
        cyc(0, 1, I_NOR, "rst_from_fault", S_IF, C_IFW, A_ADD, F_IF, DC);
        cyc(1, 1, I_NOR, "after_fault_if", S_IF, C_IF, A_ADD, F_IF, DC);
        cyc(1, 1, I_NOR, "after_fault_id", S_ID, C_ID, A_ADD, F_0, DC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
